// File: rtl/deser_rstb_sequencer.sv
// deser_rstb_sequencer
// Bring-up controller for the TDC deserializer buffer bank. On a start it holds every
// lane reset low, releases the enabled lanes one per stagger slot, waits for the bank
// to settle, then watches each lane's two data words for activity. The result is
// reported per lane and as one overall error flag.
//
// Ports
//   iclk        in   clock; idat is already retimed to this domain
//   irst        in   synchronous active-high reset
//   istart      in   start/restart pulse, accepted only when idle or done
//   ilane_en    in   [NLANE]       lane enable mask, latched on an accepted start
//   idat        in   [2*NLANE*DW]  word j = idat[j*DW +: DW]; lane k owns words 2k, 2k+1
//   orstb_deser out  [NLANE]       active-low lane resets to the buffer bank
//   olane_ok    out  [NLANE]       enabled lanes that showed activity (valid with odone)
//   obusy       out  sequence in progress
//   odone       out  sequence finished; results valid
//   oerr        out  some enabled lane showed no activity
module deser_rstb_sequencer #(
  parameter int unsigned NLANE       = 16,
  parameter int unsigned DW          = 6,
  parameter int unsigned HOLD_CYC    = 64,
  parameter int unsigned STAGGER_CYC = 8,
  parameter int unsigned SETTLE_CYC  = 32,
  parameter int unsigned CHK_CYC     = 256,
  parameter int unsigned CW          = 16
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  istart,
  input  logic [NLANE-1:0]      ilane_en,
  input  logic [2*NLANE*DW-1:0] idat,
  output logic [NLANE-1:0]      orstb_deser,
  output logic [NLANE-1:0]      olane_ok,
  output logic                  obusy,
  output logic                  odone,
  output logic                  oerr
);

  localparam int unsigned SW = (NLANE > 1) ? $clog2(NLANE) : 1;

  localparam logic [CW-1:0] HoldLd   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] StagLd   = CW'(STAGGER_CYC - 1);
  localparam logic [CW-1:0] SettleLd = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] ChkLd    = CW'(CHK_CYC - 1);
  localparam logic [SW-1:0] LastSlot = SW'(NLANE - 1);

  typedef enum logic [2:0] {StIdle, StHold, StRelease, StSettle, StCheck, StDone} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [NLANE-1:0]      en_q, en_d;
  logic [NLANE-1:0]      seen_q, seen_d;
  logic [2*NLANE*DW-1:0] prev_q, prev_d;
  logic [NLANE-1:0]      rstb_q, rstb_d;
  logic [NLANE-1:0]      ok_q, ok_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [NLANE-1:0]      act;
  logic [NLANE-1:0]      seen_upd;
  logic [NLANE-1:0]      next_lane;

  // Per-lane activity: either of the lane's two adjacent words moved since last cycle.
  always_comb begin
    act = '0;
    for (int k = 0; k < NLANE; k++) begin
      act[k] = (idat[2*k*DW +: 2*DW] != prev_q[2*k*DW +: 2*DW]);
    end
  end

  // The first check cycle only primes prev_q, so its comparison is discarded.
  assign seen_upd  = seen_q | ((cnt_q == ChkLd) ? '0 : act);
  assign next_lane = NLANE'(1) << (slot_q + SW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    en_d    = en_q;
    seen_d  = seen_q;
    prev_d  = prev_q;
    rstb_d  = rstb_q;
    ok_d    = ok_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (istart) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          en_d    = ilane_en;
          seen_d  = '0;
          rstb_d  = '0;
          ok_d    = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d   = StRelease;
          cnt_d     = StagLd;
          slot_d    = '0;
          rstb_d[0] = en_q[0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StRelease: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (slot_q == LastSlot) begin
          state_d = StSettle;
          cnt_d   = SettleLd;
        end else begin
          // Disabled lanes still burn their slot so release timing ignores the mask.
          slot_d = slot_q + SW'(1);
          cnt_d  = StagLd;
          rstb_d = rstb_q | (en_q & next_lane);
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StCheck;
          cnt_d   = ChkLd;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StCheck: begin
        prev_d = idat;
        seen_d = seen_upd;
        if (cnt_q == '0) begin
          state_d = StDone;
          ok_d    = en_q & seen_upd;
          err_d   = |(en_q & ~seen_upd);
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      slot_q  <= '0;
      en_q    <= '0;
      seen_q  <= '0;
      prev_q  <= '0;
      rstb_q  <= '0;
      ok_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      en_q    <= en_d;
      seen_q  <= seen_d;
      prev_q  <= prev_d;
      rstb_q  <= rstb_d;
      ok_q    <= ok_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign orstb_deser = rstb_q;
  assign olane_ok    = ok_q;
  assign obusy       = busy_q;
  assign odone       = done_q;
  assign oerr        = err_q;

endmodule

// File: tb/tb_deser_rstb_sequencer.sv
// Bench for deser_rstb_sequencer with default parameters. Tests push the expected lane
// release times and final results into queues when they start a sequence; a monitor pops
// and compares them as the DUT produces rising resets and the done flag.
module tb_deser_rstb_sequencer;

  localparam int NLANE  = 16;
  localparam int DW     = 6;
  localparam int HOLD   = 64;
  localparam int STAG   = 8;
  localparam int SETTLE = 32;
  localparam int CHK    = 256;
  localparam int TOTAL  = HOLD + NLANE * STAG + SETTLE + CHK;

  logic                  clk = 1'b0;
  logic                  irst = 1'b1;
  logic                  istart = 1'b0;
  logic [NLANE-1:0]      ilane_en = '0;
  logic [2*NLANE*DW-1:0] idat = '0;
  logic [NLANE-1:0]      orstb_deser, olane_ok;
  logic                  obusy, odone, oerr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Data source state
  bit rand_data = 1'b0;
  int stuck_lane = -1;
  int dcnt = 0;

  typedef struct {int t; int lane;} rise_t;
  typedef struct {int t; logic [NLANE-1:0] ok; logic err;} done_t;
  rise_t rise_q[$];
  done_t done_q[$];

  deser_rstb_sequencer dut (
    .iclk        (clk),
    .irst        (irst),
    .istart      (istart),
    .ilane_en    (ilane_en),
    .idat        (idat),
    .orstb_deser (orstb_deser),
    .olane_ok    (olane_ok),
    .obusy       (obusy),
    .odone       (odone),
    .oerr        (oerr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Each word counts up with a per-word offset; a stuck lane holds 6'h2A on both words.
  initial forever begin
    @(negedge clk);
    dcnt = dcnt + 1;
    for (int j = 0; j < 2 * NLANE; j++) begin
      if (rand_data) idat[j*DW +: DW] = DW'($urandom);
      else if (j / 2 == stuck_lane) idat[j*DW +: DW] = 6'h2A;
      else idat[j*DW +: DW] = DW'(dcnt + j);
    end
  end

  // Scoreboard monitor
  initial begin
    logic [NLANE-1:0] prev_rstb;
    logic             prev_done;
    logic [NLANE-1:0] rose;
    rise_t            r;
    done_t            d;
    prev_rstb = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      rose = orstb_deser & ~prev_rstb;
      for (int k = 0; k < NLANE; k++) begin
        if (rose[k] === 1'b1) begin
          checks++;
          if (rise_q.size() == 0) begin
            errors++;
            $display("FAIL rstb_rise: lane %0d rose at cycle %0d, required no rise", k, cyc);
          end else begin
            r = rise_q.pop_front();
            if (r.lane != k || r.t != cyc) begin
              errors++;
              $display("FAIL rstb_rise: lane %0d at cycle %0d, required lane %0d at cycle %0d",
                       k, cyc, r.lane, r.t);
            end
          end
        end
      end
      if (odone === 1'b1 && prev_done !== 1'b1) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL done_rise: odone rose at cycle %0d, required no rise", cyc);
        end else begin
          d = done_q.pop_front();
          if (d.t != cyc || olane_ok !== d.ok || oerr !== d.err) begin
            errors++;
            $display("FAIL done_rise: cycle %0d ok %h err %b, required cycle %0d ok %h err %b",
                     cyc, olane_ok, oerr, d.t, d.ok, d.err);
          end
        end
      end
      prev_rstb = orstb_deser;
      prev_done = odone;
    end
  end

  // Drive a one-cycle start; e returns the cycle count of the edge that accepted it.
  task automatic do_start(input logic [NLANE-1:0] en, output int e);
    @(negedge clk);
    ilane_en = en;
    istart   = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    @(negedge clk);
    istart = 1'b0;
  endtask

  // Reference model: enabled lanes rise in slot order, results follow from the stuck mask.
  task automatic expect_run(input int e, input logic [NLANE-1:0] en,
                            input logic [NLANE-1:0] stuck, input int last_lane,
                            input bit with_done);
    rise_t r;
    done_t d;
    for (int k = 0; k <= last_lane; k++) begin
      if (en[k]) begin
        r.t = e + HOLD + k * STAG;
        r.lane = k;
        rise_q.push_back(r);
      end
    end
    if (with_done) begin
      d.t   = e + TOTAL;
      d.ok  = en & ~stuck;
      d.err = |(en & stuck);
      done_q.push_back(d);
    end
  endtask

  task automatic wait_done(output bit hit);
    hit = 1'b0;
    for (int i = 0; i < TOTAL + 20; i++) begin
      @(negedge clk);
      if (odone === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    rand_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ilane_en = NLANE'($urandom);
      istart   = 1'($urandom);
    end
    @(negedge clk);
    checks += 5;
    if (orstb_deser !== '0) begin errors++; $display("FAIL reset_rstb: %h, required 0", orstb_deser); end
    if (olane_ok !== '0) begin errors++; $display("FAIL reset_ok: %h, required 0", olane_ok); end
    if (obusy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b, required 0", obusy); end
    if (odone !== 1'b0) begin errors++; $display("FAIL reset_done: %b, required 0", odone); end
    if (oerr !== 1'b0) begin errors++; $display("FAIL reset_err: %b, required 0", oerr); end
    irst = 1'b0;
    istart = 1'b0;
    rand_data = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_run(input string name, input logic [NLANE-1:0] en, input int stuck);
    int e;
    bit hit;
    logic [NLANE-1:0] smask;
    smask = '0;
    if (stuck >= 0) smask[stuck] = 1'b1;
    stuck_lane = stuck;
    do_start(en, e);
    expect_run(e, en, smask, NLANE - 1, 1'b1);
    wait_done(hit);
    checks += 3;
    if (!hit) begin errors++; $display("FAIL %s_timeout: odone=%b, required 1", name, odone); end
    if (rise_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d rises %0d dones left, required 0", name,
               rise_q.size(), done_q.size());
      rise_q.delete();
      done_q.delete();
    end
    if (orstb_deser !== en || obusy !== 1'b0) begin
      errors++;
      $display("FAIL %s_final: rstb %h busy %b, required rstb %h busy 0", name,
               orstb_deser, obusy, en);
    end
    stuck_lane = -1;
  endtask

  task automatic test_ignore_and_reset();
    int e;
    do_start('1, e);
    expect_run(e, '1, '0, 7, 1'b0);
    while (cyc < e + 70) @(negedge clk);
    istart = 1'b1;
    @(negedge clk);
    istart = 1'b0;
    while (cyc < e + 90) @(negedge clk);
    istart = 1'b1;
    @(negedge clk);
    istart = 1'b0;
    while (cyc < e + HOLD + 7 * STAG + 2) @(negedge clk);
    irst = 1'b1;
    istart = 1'b1;
    @(posedge clk);
    #1;
    checks += 3;
    if (orstb_deser !== '0 || olane_ok !== '0) begin
      errors++;
      $display("FAIL midreset_lanes: rstb %h ok %h, required 0 0", orstb_deser, olane_ok);
    end
    if (obusy !== 1'b0 || odone !== 1'b0 || oerr !== 1'b0) begin
      errors++;
      $display("FAIL midreset_flags: busy %b done %b err %b, required 000", obusy, odone, oerr);
    end
    if (rise_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_rises: %0d pending, required 0", rise_q.size());
      rise_q.delete();
    end
    @(negedge clk);
    irst = 1'b0;
    istart = 1'b0;
    repeat (HOLD + 10) @(negedge clk);
    checks++;
    if (obusy !== 1'b0 || orstb_deser !== '0) begin
      errors++;
      $display("FAIL midreset_idle: busy %b rstb %h, required 0 0", obusy, orstb_deser);
    end
  endtask

  task automatic test_restart_from_done();
    int e;
    bit hit;
    do_start(16'h0001, e);
    checks += 2;
    if (orstb_deser !== '0 || olane_ok !== '0) begin
      errors++;
      $display("FAIL restart_clear: rstb %h ok %h, required 0 0", orstb_deser, olane_ok);
    end
    if (obusy !== 1'b1 || odone !== 1'b0) begin
      errors++;
      $display("FAIL restart_flags: busy %b done %b, required 1 0", obusy, odone);
    end
    ilane_en = '1;  // must not affect the running sequence
    expect_run(e, 16'h0001, '0, NLANE - 1, 1'b1);
    wait_done(hit);
    checks += 2;
    if (!hit) begin errors++; $display("FAIL restart_timeout: odone=%b, required 1", odone); end
    if (rise_q.size() != 0 || done_q.size() != 0 || orstb_deser !== 16'h0001) begin
      errors++;
      $display("FAIL restart_final: rstb %h pending %0d/%0d, required 0001 0/0",
               orstb_deser, rise_q.size(), done_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_run("all_lanes", 16'hFFFF, -1);
    test_run("stuck5", 16'hFFFF, 5);
    test_run("half_mask", 16'h00FF, -1);
    test_ignore_and_reset();
    test_run("no_lanes", 16'h0000, -1);
    test_restart_from_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
